// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NREQ consumers.
// A grant lasts up to BURST pops and ends early if the owner drops its request.
module fifo_rd_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic             r_clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             empty,
    input  logic [WIDTH-1:0] rd_data,
    output logic             rd_rq,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] dout,
    output logic [NREQ-1:0]  dvalid,
    output logic             busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [NREQ-1:0]  r_gnt;
    logic [IW-1:0]    r_gidx;
    logic [IW-1:0]    r_last;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic [NREQ-1:0]  r_dvalid;

    logic             w_busy;
    logic             w_own_req;
    logic             w_pop;
    logic             w_start;
    logic             w_final;
    logic             w_found;
    logic [CW-1:0]    w_cnt_inc;
    logic [IW-1:0]    w_pick;
    logic [IW-1:0]    w_idx;
    logic [NREQ-1:0]  w_pick_ohot;

    // Search upward from the consumer after the last owner, wrapping once.
    always_comb begin : arb_search
        int j;
        j       = 0;
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(r_last) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            w_idx = j[IW-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_pick_ohot = NREQ'(1) << w_pick;
    assign w_own_req   = |(r_gnt & req);
    assign w_pop       = w_busy & w_own_req & ~empty;
    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_final     = w_pop && (w_cnt_inc == CW'(BURST));
    assign w_start     = (r_state == S_IDLE) && !empty && w_found;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_BURST;
                end
            end
            S_BURST: begin
                if (!w_own_req || w_final) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == S_BURST);
        rd_rq  = w_pop;
        busy   = w_busy;
    end

    // Exit always clears the grant in the same edge, leaving one idle cycle.
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= '0;
            r_gidx   <= '0;
            r_last   <= IW'(NREQ - 1);
            r_cnt    <= '0;
            r_dout   <= '0;
            r_dvalid <= '0;
        end else begin
            r_dvalid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_gnt  <= w_pick_ohot;
                        r_gidx <= w_pick;
                        r_cnt  <= '0;
                    end
                end
                S_BURST: begin
                    if (!w_own_req) begin
                        r_gnt  <= '0;
                        r_last <= r_gidx;
                    end else if (w_pop) begin
                        r_dout   <= rd_data;
                        r_dvalid <= r_gnt;
                        r_cnt    <= w_cnt_inc;
                        if (w_final) begin
                            r_gnt  <= '0;
                            r_last <= r_gidx;
                        end
                    end
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign dout   = r_dout;
    assign dvalid = r_dvalid;

endmodule
